// File: rtl/vm_pkg.sv
// Shared types and encodings for the multi-product vending controller.
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_PAYOUT
    } vm_state_e;

    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    localparam logic PAY_HALF = 1'b0;
    localparam logic PAY_ONE  = 1'b1;

    // Credit value of a coin code in half-yuan units; invalid codes are worth nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_HALF: return 2'd1;
            COIN_ONE:  return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_payout.sv
// Greedy change dispenser: counts an amount down one physical coin per
// ready/valid transfer, offering 1-yuan coins while at least 2 units remain.
module vm_change_payout
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                pay_ready,
    output logic                pay_valid,
    output logic                pay_coin,
    output logic [CREDIT_W-1:0] remaining,
    output logic                done
);

    logic [CREDIT_W-1:0] amt_q, amt_d, step;
    logic                valid_q, coin_q;

    assign step      = (coin_q == PAY_ONE) ? CREDIT_W'(2) : CREDIT_W'(1);
    assign done      = valid_q && pay_ready && (amt_q == step);
    assign pay_valid = valid_q;
    assign pay_coin  = coin_q;
    assign remaining = amt_q;

    always_comb begin
        amt_d = amt_q;
        if (start) begin
            amt_d = amount;
        end else if (valid_q && pay_ready) begin
            amt_d = amt_q - step;
        end
    end

    // Offer and coin type only move on load or transfer, so they hold through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            amt_q   <= '0;
            valid_q <= 1'b0;
            coin_q  <= PAY_HALF;
        end else begin
            amt_q   <= amt_d;
            valid_q <= (amt_d != '0);
            coin_q  <= (amt_d >= CREDIT_W'(2)) ? PAY_ONE : PAY_HALF;
        end
    end

endmodule

// File: rtl/vm_multi_product.sv
// Multi-product vending controller: credit accumulation, per-product price
// check, vend pulse and hand-off of change/refund to the payout engine.
module vm_multi_product
    import vm_pkg::*;
#(
    parameter int                         N_PROD     = 4,
    parameter int                         CREDIT_W   = 5,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {5'd6, 5'd4, 5'd3, 5'd5},
    parameter int                         MAX_CREDIT = 10,
    localparam int                        SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_short,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_id,
    output logic                pay_valid,
    output logic                pay_coin,
    input  logic                pay_ready,
    output logic                busy
);

    if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    for (genvar g = 0; g < N_PROD; g++) begin : g_price_chk
        if (int'(PRICES[g*CREDIT_W +: CREDIT_W]) > MAX_CREDIT) begin : g_bad_price
            $error("product price exceeds MAX_CREDIT");
        end
    end

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    vend_id_q, vend_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_short_q, sel_short_d;
    logic                vend_valid_q, vend_valid_d;
    logic                busy_q, busy_d;

    logic                pay_start, pay_done;
    logic [CREDIT_W-1:0] pay_amount, pay_remaining;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok, coin_blocked;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_found, sel_ok;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        sel_short_d   = 1'b0;
        vend_valid_d  = 1'b0;
        pay_start     = 1'b0;
        pay_amount    = credit_q;

        coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units(coin_val));
        coin_ok  = (coin_units(coin_val) != 2'd0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

        sel_found = 1'b0;
        sel_price = '0;
        for (int p = 0; p < N_PROD; p++) begin
            if (int'(sel_id) == p) begin
                sel_found = 1'b1;
                sel_price = PRICES[p*CREDIT_W +: CREDIT_W];
            end
        end
        sel_ok = sel_found && (credit_q >= sel_price);

        // In CREDIT a same-cycle cancel or selection takes precedence over a coin.
        coin_blocked = (state_q == ST_CREDIT) && (cancel || sel_valid);

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if ((state_q == ST_CREDIT) && cancel) begin
                    state_d   = ST_PAYOUT;
                    pay_start = 1'b1;
                    credit_d  = '0;
                end else if (sel_valid) begin
                    if ((state_q == ST_CREDIT) && sel_ok) begin
                        credit_d     = credit_q - sel_price;
                        vend_id_d    = sel_id;
                        vend_valid_d = 1'b1;
                        state_d      = ST_VEND;
                    end else begin
                        sel_short_d = 1'b1;
                    end
                end
                if (coin_valid) begin
                    if (!coin_blocked && coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (credit_q != '0) begin
                    state_d   = ST_PAYOUT;
                    pay_start = 1'b1;
                    credit_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYOUT: begin
                coin_reject_d = coin_valid;
                if (pay_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_VEND) || (state_d == ST_PAYOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_short_q   <= 1'b0;
            vend_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            sel_short_q   <= sel_short_d;
            vend_valid_q  <= vend_valid_d;
            busy_q        <= busy_d;
        end
    end

    vm_change_payout #(
        .CREDIT_W (CREDIT_W)
    ) u_payout (
        .clk       (clk),
        .rst       (rst),
        .start     (pay_start),
        .amount    (pay_amount),
        .pay_ready (pay_ready),
        .pay_valid (pay_valid),
        .pay_coin  (pay_coin),
        .remaining (pay_remaining),
        .done      (pay_done)
    );

    // While paying out, the visible credit is what is still owed.
    assign credit      = (state_q == ST_PAYOUT) ? pay_remaining : credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_short   = sel_short_q;
    assign vend_valid  = vend_valid_q;
    assign vend_id     = vend_id_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vm_multi_product.sv
// Directed bench for vm_multi_product with a payout-coin scoreboard queue.
module tb_vm_multi_product;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic [4:0] credit;
    logic       coin_reject;
    logic       sel_short;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       pay_valid;
    logic       pay_coin;
    logic       pay_ready;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_q[$];

    vm_multi_product dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .credit      (credit),
        .coin_reject (coin_reject),
        .sel_short   (sel_short),
        .vend_valid  (vend_valid),
        .vend_id     (vend_id),
        .pay_valid   (pay_valid),
        .pay_coin    (pay_coin),
        .pay_ready   (pay_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0;
        coin_val   = 2'b00;
        sel_valid  = 1'b0;
        sel_id     = 2'd0;
        cancel     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, credit, 0);
        check({tag, "_outs"}, {coin_reject, sel_short, vend_valid, vend_id, pay_valid, pay_coin, busy}, 0);
    endtask

    task automatic insert_coin(input logic [1:0] code, input int exp_credit, input logic exp_rej);
        coin_valid = 1'b1;
        coin_val   = code;
        tick();
        idle_inputs();
        check("coin_credit", credit, exp_credit);
        check("coin_reject", coin_reject, exp_rej);
    endtask

    // Pops one expected coin per observed transfer and tracks owed credit.
    task automatic drain(input int owed, input int budget);
        int rem = owed;
        int left = budget;
        logic exp_coin;
        pay_ready = 1'b1;
        while (exp_q.size() > 0 && left > 0) begin
            if (pay_valid) begin
                exp_coin = exp_q.pop_front();
                check("pay_coin", pay_coin, exp_coin);
                check("pay_credit", credit, rem);
                check("pay_busy", busy, 1);
                rem = rem - (exp_coin ? 2 : 1);
            end
            tick();
            left--;
        end
        check("payout_left", exp_q.size(), 0);
        exp_q.delete();
        check("pay_end_valid", pay_valid, 0);
        check("pay_end_busy", busy, 0);
        check("pay_end_credit", credit, 0);
        pay_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        pay_ready = 1'b0;
        idle_inputs();

        // Reset with random stimulus on every input
        for (int i = 0; i < 2; i++) begin
            coin_valid = 1'($urandom);
            coin_val   = 2'($urandom);
            sel_valid  = 1'($urandom);
            sel_id     = 2'($urandom);
            cancel     = 1'($urandom);
            pay_ready  = 1'($urandom);
            tick();
            check_all_zero("reset");
        end
        rst = 1'b0;
        idle_inputs();
        pay_ready = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Invalid coin code in IDLE
        insert_coin(2'b11, 0, 1'b1);

        // Exact payment, no change
        insert_coin(2'b10, 2, 1'b0);
        insert_coin(2'b10, 4, 1'b0);
        insert_coin(2'b01, 5, 1'b0);
        sel_valid = 1'b1;
        sel_id    = 2'd0;
        tick();
        idle_inputs();
        check("exact_vend", vend_valid, 1);
        check("exact_id", vend_id, 0);
        check("exact_credit", credit, 0);
        check("exact_busy", busy, 1);
        tick();
        check("exact_vend_off", vend_valid, 0);
        check("exact_no_pay", pay_valid, 0);
        check("exact_idle", busy, 0);

        // Change with a stalled dispenser
        insert_coin(2'b10, 2, 1'b0);
        insert_coin(2'b10, 4, 1'b0);
        insert_coin(2'b10, 6, 1'b0);
        sel_valid = 1'b1;
        sel_id    = 2'd1;
        tick();
        idle_inputs();
        check("chg_vend", vend_valid, 1);
        check("chg_id", vend_id, 1);
        check("chg_credit", credit, 3);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", pay_valid, 1);
            check("stall_coin", pay_coin, 1);
            check("stall_credit", credit, 3);
        end
        drain(3, 20);

        // Insufficient credit
        insert_coin(2'b10, 2, 1'b0);
        insert_coin(2'b01, 3, 1'b0);
        sel_valid = 1'b1;
        sel_id    = 2'd3;
        tick();
        idle_inputs();
        check("short_pulse", sel_short, 1);
        check("short_credit", credit, 3);
        check("short_vend", vend_valid, 0);
        tick();
        check("short_off", sel_short, 0);

        // Overflow then cancel
        insert_coin(2'b10, 5, 1'b0);
        insert_coin(2'b10, 7, 1'b0);
        insert_coin(2'b10, 9, 1'b0);
        insert_coin(2'b10, 9, 1'b1);
        tick();
        check("ovf_rej_off", coin_reject, 0);
        cancel = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        drain(9, 30);

        // Cancel, selection and coin in the same cycle
        insert_coin(2'b10, 2, 1'b0);
        insert_coin(2'b10, 4, 1'b0);
        insert_coin(2'b01, 5, 1'b0);
        cancel     = 1'b1;
        sel_valid  = 1'b1;
        sel_id     = 2'd0;
        coin_valid = 1'b1;
        coin_val   = 2'b01;
        tick();
        idle_inputs();
        check("sim_reject", coin_reject, 1);
        check("sim_vend", vend_valid, 0);
        check("sim_short", sel_short, 0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        drain(5, 20);

        // Reset in the middle of a payout
        insert_coin(2'b10, 2, 1'b0);
        insert_coin(2'b10, 4, 1'b0);
        cancel = 1'b1;
        tick();
        idle_inputs();
        pay_ready = 1'b1;
        tick();
        check("mid_credit", credit, 2);
        check("mid_valid", pay_valid, 1);
        pay_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pay_valid", pay_valid, 0);
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        insert_coin(2'b01, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vm_multi_product.md
# vm_multi_product

Parametrised successor to the single-product vending controller. It holds a credit counter in half-yuan units and sells up to `N_PROD` products, each with its own price. It vends on an explicit product selection, refunds on cancel, and pays change or refunds as a sequence of physical coins over a ready/valid handshake to the coin dispenser. It sits between the coin acceptor front end and the dispenser and product-release drivers.

## Interface
Parameters:
- `N_PROD`, default 4: number of products.
- `CREDIT_W`, default 5: credit width, in 0.5-yuan units.
- `PRICES`, default {6,4,3,5}: packed `N_PROD*CREDIT_W` vector. Product 0 is in the LSBs, so p0=5, p1=3, p2=4, p3=6 units.
- `MAX_CREDIT`, default 10: highest credit accepted, in units (5 yuan).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `coin_valid`  in  1  coin present this cycle.
- `coin_val`  in  2  coin encoding: 01 = 0.5 yuan, 10 = 1 yuan; 00 and 11 are invalid.
- `sel_valid`  in  1  product selection strobe.
- `sel_id`  in  $clog2(N_PROD)  selected product.
- `cancel`  in  1  refund request.
- `credit`  out  CREDIT_W  current credit (registered).
- `coin_reject`  out  1  one-cycle pulse: the coin was returned mechanically and no credit was given.
- `sel_short`  out  1  one-cycle pulse: the selection was refused for insufficient credit.
- `vend_valid`  out  1  one-cycle pulse: release the product.
- `vend_id`  out  $clog2(N_PROD)  product being released; valid with `vend_valid`.
- `pay_valid`  out  1  payout coin offered.
- `pay_coin`  out  1  payout coin type: 1 = 1 yuan, 0 = 0.5 yuan.
- `pay_ready`  in  1  dispenser accepts the offered coin.
- `busy`  out  1  high in VEND or PAYOUT.

## Operation
- States: IDLE (credit 0), CREDIT, VEND, PAYOUT.
- Unit values: coin_val 01 adds 1 unit; 10 adds 2 units.
- Coin acceptance in IDLE or CREDIT: a valid coin is accepted when credit+value <= MAX_CREDIT.
  - On acceptance, credit += value and the state goes to CREDIT.
  - Otherwise (invalid encoding or overflow), pulse `coin_reject` and leave credit unchanged.
- Coins in VEND or PAYOUT: always rejected.
- Selection in CREDIT with `sel_valid`:
  - If `sel_id` >= N_PROD or credit < PRICES[sel_id], pulse `sel_short`; credit and state are unchanged.
  - Otherwise, credit -= price and go to VEND.
- Selection in IDLE: `sel_valid` pulses `sel_short`.
- VEND (one cycle): `vend_valid`=1 and `vend_id` = the latched id. Next state is PAYOUT if credit > 0, else IDLE.
- Cancel in CREDIT goes to PAYOUT with the full credit. Cancel in IDLE, VEND or PAYOUT is ignored.
- PAYOUT, greedy decomposition:
  - `pay_valid`=1 and `pay_coin` = (credit >= 2).
  - On `pay_valid && pay_ready`, credit -= 2 or 1.
  - When credit reaches 0, go to IDLE and drop `pay_valid` in the same cycle.
- Same-cycle priority in CREDIT: cancel > sel > coin.
  - A coin that loses to cancel or sel is rejected (`coin_reject`).
  - A sel that loses to cancel is dropped silently.
- Credit never wraps. The MAX_CREDIT check guarantees the sum fits in CREDIT_W. Elaboration must check that MAX_CREDIT < 2^CREDIT_W and that every price is <= MAX_CREDIT.

## Timing
- Reset values: state=IDLE, credit=0, and all pulses, `pay_valid`, `busy`, `vend_id` and `pay_coin` are 0.
- Reset mid-operation discards credit and any pending payout (documented coin loss). `pay_valid` is 0 from the cycle after `rst` is sampled.
- Coin accepted at edge t: `credit` is updated from t+1. `coin_reject` is high during t+1 only.
- Selection accepted at t:
  - `credit` shows the reduced value and `vend_valid` is high during t+1.
  - PAYOUT starts at t+2 with `pay_valid` high from t+2.
- `pay_valid` and `pay_coin` are held stable while `pay_ready` is low. They change only after a transfer.
- The dispenser can take one coin per cycle at most, so throughput is 1 coin/cycle with `pay_ready` held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `vm_pkg`:
  - state enum;
  - coin encodings `COIN_HALF`=2'b01 and `COIN_ONE`=2'b10;
  - payout encodings `PAY_HALF`=0 and `PAY_ONE`=1;
  - a unit-value function for coin encodings.
- Sub-module `vm_change_payout`:
  - Owns the PAYOUT credit down-count, the greedy coin choice and the ready/valid handshake.
  - Loaded with an amount plus a start strobe.
  - Returns `done` and its remaining amount. The top-level muxes that remaining amount onto `credit` while in PAYOUT.
- Top-level holds the FSM, the credit accumulator, the price lookup and the pulse generation.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs. All outputs must be 0 and `credit`=0 during reset and the cycle after.
- Exact payment, no change: coins 10, 10, 01 (credit 5), then sel 0. `vend_valid`=1 with `vend_id`=0 one cycle after sel, `credit`=0, no `pay_valid`, state returns to IDLE.
- Change with stall: three 1-yuan coins (credit 6), then sel 1 (price 3). Vend id 1, then payout 1 yuan followed by 0.5 yuan. Hold `pay_ready` low for 3 cycles on the first coin; `pay_valid`=1 and `pay_coin`=1 must stay stable throughout.
- Insufficient credit: credit 3, sel 3 (price 6). `sel_short` pulses, `credit` stays 3 and `vend_valid` stays 0.
- Overflow then cancel: credit 9, insert a 1-yuan coin. `coin_reject` pulses and `credit` stays 9. Then cancel: payout sequence 1, 1, 1, 1, 0.5, then IDLE.
- Simultaneous events: with credit 5, drive cancel, sel 0 and a coin in the same cycle. Result is a refund of 5 units (coins 1, 1, 0.5), `coin_reject` pulses and no vend occurs. Separately, assert `rst` mid-payout: `pay_valid` drops and `credit`=0 the next cycle.
